// File: rtl/ldp_pkg.sv
// rtl/ldp_pkg.sv - shared types and helpers for the ldp packet generator
package ldp_pkg;

    localparam int LDP_WORD_W = 32;
    // Widest stream the replication helper supports; callers cast down to their DW.
    localparam int LDP_MAX_DW = 1024;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_CSUM   = 2'd2,
        S_FINISH = 2'd3
    } ldp_state_t;

    function automatic logic [LDP_MAX_DW-1:0] ldp_replicate(input logic [LDP_WORD_W-1:0] i_word);
        return {(LDP_MAX_DW/LDP_WORD_W){i_word}};
    endfunction

endpackage

// File: rtl/ldp_beat_fmt.sv
// rtl/ldp_beat_fmt.sv - registered TVALID/TDATA/TLAST stage with hold-on-stall; XOR accumulator under LDP_GEN_CHECKSUM_EN
module ldp_beat_fmt #(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_tready,
    input  logic          i_valid_next,
    input  logic          i_last_next,
    input  logic [31:0]   i_word_next,
`ifdef LDP_GEN_CHECKSUM_EN
    input  logic          i_csum_sel,
    input  logic          i_acc_clr,
    input  logic          i_acc_en,
`endif
    output logic          o_tvalid,
    output logic          o_tlast,
    output logic [DW-1:0] o_tdata
);
    import ldp_pkg::*;

    logic          r_tvalid;
    logic          r_tlast;
    logic [DW-1:0] r_tdata;
    logic          w_adv;
    logic [31:0]   w_word;

    // The stage only reloads when empty or when the current beat is consumed.
    assign w_adv = !r_tvalid || i_tready;

`ifdef LDP_GEN_CHECKSUM_EN
    logic [31:0] r_acc;

    // The checksum beat folds in the payload word being handed off this cycle.
    assign w_word = i_csum_sel ? (r_acc ^ r_tdata[31:0]) : i_word_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_acc_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc ^ r_tdata[31:0];
        end
    end
`else
    assign w_word = i_word_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else if (w_adv) begin
            r_tvalid <= i_valid_next;
            r_tlast  <= i_last_next;
            if (i_valid_next) begin
                r_tdata <= DW'(ldp_replicate(w_word));
            end
        end
    end

    assign o_tvalid = r_tvalid;
    assign o_tlast  = r_tlast;
    assign o_tdata  = r_tdata;

endmodule

// File: rtl/ldp_packet_gen.sv
// rtl/ldp_packet_gen.sv - start-triggered AXIS counting-pattern burst generator; LDP_GEN_CHECKSUM_EN adds a trailing XOR beat
module ldp_packet_gen #(
    parameter int DW = 256,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] packet_count,
    input  logic [15:0]   packet_beats,
    output logic [DW-1:0] AXIS_TDATA,
    output logic          AXIS_TVALID,
    output logic          AXIS_TLAST,
    input  logic          AXIS_TREADY,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pkts_sent
);
    import ldp_pkg::*;

    ldp_state_t    r_state;
    ldp_state_t    w_state_next;
    logic [CW-1:0] r_pkt_remaining;
    logic [CW-1:0] r_pkts_sent;
    logic [15:0]   r_beat_len;
    logic [15:0]   r_beat_idx;
    logic [31:0]   r_word_ctr;

    logic          w_hs;
    logic          w_start;
    logic          w_last_beat;
    logic          w_pay_last;
    logic          w_pkt_done;
    logic          w_final;
    logic [15:0]   w_len_next;
    logic [15:0]   w_idx_next;
    logic [31:0]   w_word_next;
    logic          w_valid_next;
    logic          w_last_next;

    assign w_hs        = AXIS_TVALID & AXIS_TREADY;
    assign w_start     = (r_state == S_IDLE) & start;
    assign w_last_beat = (r_beat_idx == r_beat_len - 16'd1);
    assign w_pay_last  = (r_state == S_SEND) & w_hs & w_last_beat;
`ifdef LDP_GEN_CHECKSUM_EN
    assign w_pkt_done  = (r_state == S_CSUM) & w_hs;
`else
    assign w_pkt_done  = w_pay_last;
`endif
    assign w_final     = w_pkt_done & (r_pkt_remaining == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (packet_count == '0) ? S_FINISH : S_SEND;
                end
            end
            S_SEND: begin
`ifdef LDP_GEN_CHECKSUM_EN
                if (w_pay_last) w_state_next = S_CSUM;
`else
                if (w_pkt_done) w_state_next = w_final ? S_FINISH : S_SEND;
`endif
            end
`ifdef LDP_GEN_CHECKSUM_EN
            S_CSUM: begin
                if (w_pkt_done) w_state_next = w_final ? S_FINISH : S_SEND;
            end
`endif
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_SEND) || (r_state == S_CSUM);
        done = (r_state == S_FINISH);
    end

    // Next-cycle counters, so the output stage can be loaded with the upcoming beat.
    always_comb begin
        w_len_next  = r_beat_len;
        w_idx_next  = r_beat_idx;
        w_word_next = r_word_ctr;
        if (w_start) begin
            w_len_next  = (packet_beats == 16'd0) ? 16'd1 : packet_beats;
            w_idx_next  = 16'd0;
            w_word_next = 32'd0;
        end else if ((r_state == S_SEND) && w_hs) begin
            w_idx_next  = w_last_beat ? 16'd0 : r_beat_idx + 16'd1;
            w_word_next = r_word_ctr + 32'd1;
        end
    end

    assign w_valid_next = (w_state_next == S_SEND) || (w_state_next == S_CSUM);
`ifdef LDP_GEN_CHECKSUM_EN
    assign w_last_next  = (w_state_next == S_CSUM);
`else
    assign w_last_next  = (w_state_next == S_SEND) && (w_idx_next == w_len_next - 16'd1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_remaining <= '0;
            r_pkts_sent     <= '0;
            r_beat_len      <= 16'd1;
            r_beat_idx      <= 16'd0;
            r_word_ctr      <= 32'd0;
        end else begin
            r_beat_len <= w_len_next;
            r_beat_idx <= w_idx_next;
            r_word_ctr <= w_word_next;
            if (w_start) begin
                r_pkt_remaining <= packet_count;
                r_pkts_sent     <= '0;
            end else if (w_pkt_done) begin
                r_pkt_remaining <= r_pkt_remaining - CW'(1);
                r_pkts_sent     <= r_pkts_sent + CW'(1);
            end
        end
    end

    assign pkts_sent = r_pkts_sent;

    ldp_beat_fmt #(
        .DW (DW)
    ) u_beat_fmt (
        .clk          (clk),
        .reset        (reset),
        .i_tready     (AXIS_TREADY),
        .i_valid_next (w_valid_next),
        .i_last_next  (w_last_next),
        .i_word_next  (w_word_next),
`ifdef LDP_GEN_CHECKSUM_EN
        .i_csum_sel   (w_state_next == S_CSUM),
        .i_acc_clr    (w_start | w_pkt_done),
        .i_acc_en     (w_hs & (r_state == S_SEND)),
`endif
        .o_tvalid     (AXIS_TVALID),
        .o_tlast      (AXIS_TLAST),
        .o_tdata      (AXIS_TDATA)
    );

endmodule

// File: doc/ldp_packet_gen.md
# ldp_packet_gen

Packet generator that sits directly downstream of the AXI4-Lite control slave. It consumes that slave's one-cycle `start` pulse and emits a burst of test packets on an AXI4-Stream master. Packet count and length are latched at start. Payload is a deterministic counting pattern, so downstream checkers can verify order and integrity.

## Interface
Parameters:
- `DW`, default 256: AXIS data width in bits; a multiple of 32, at least 32.
- `CW`, default 32: width of the packet-count input and the `pkts_sent` counter.

Ports:
- `clk` — in, 1: the single clock.
- `reset` — in, 1: synchronous, active-high.
- `start` — in, 1: one-cycle pulse from the control slave.
- `packet_count` — in, CW: number of packets per burst; sampled on an accepted start.
- `packet_beats` — in, 16: payload beats per packet; sampled on an accepted start; 0 is treated as 1.
- `AXIS_TDATA` — out, DW: stream data.
- `AXIS_TVALID` — out, 1: stream valid.
- `AXIS_TLAST` — out, 1: last beat of a packet.
- `AXIS_TREADY` — in, 1: downstream ready.
- `busy` — out, 1: burst in progress.
- `done` — out, 1: one-cycle pulse at burst completion.
- `pkts_sent` — out, CW: packets completed in the current or most recent burst.

## Operation
- States: IDLE, SEND, CSUM (present only with the checksum feature), FINISH.
- IDLE:
  - On `start`, latch `packet_count` into `pkt_remaining`, `max(packet_beats,1)` into `beat_len`, clear `word_ctr`, `beat_idx` and `pkts_sent`, and set `busy`.
  - If the latched count is 0, go to FINISH. Otherwise go to SEND.
- Start pulses outside IDLE are ignored. They are not queued.
- SEND:
  - `AXIS_TVALID`=1.
  - `AXIS_TDATA` = 32-bit `word_ctr` replicated DW/32 times.
  - Each handshake (TVALID & TREADY) increments `word_ctr` (wraps at 2^32) and `beat_idx`.
  - Handshake on beat `beat_len-1`:
    - With checksum: go to CSUM.
    - Without checksum: TLAST=1 on that beat; `pkts_sent`+1, `pkt_remaining`−1, `beat_idx` cleared; next state is SEND, or FINISH if `pkt_remaining` was 1.
- CSUM:
  - One beat with TLAST=1. Data = XOR of all payload words of the current packet, replicated.
  - `word_ctr` is not advanced.
  - On handshake, update `pkts_sent` and `pkt_remaining` as above, then go to SEND or FINISH.
- FINISH: `done`=1 for exactly one cycle, `busy`=0 from the same cycle, then return to IDLE.
- `word_ctr` continues across packets within a burst. It restarts at 0 on each new burst.
- Reset values: TVALID=0, TLAST=0, TDATA=0, `busy`=0, `done`=0, `pkts_sent`=0, state IDLE.
- Reset mid-burst aborts immediately. TVALID drops the cycle after reset is sampled, even without a handshake; a mid-packet drop is permitted on reset only.

## Timing
- `start` sampled at cycle T: `busy`=1 and TVALID=1 (first beat, word 0) at T+1.
- Zero-count burst: `start` at T → `done`=1 at T+1 → `busy` never asserted, or for 0 cycles.
- TDATA, TLAST and TVALID are registered. While TVALID & !TREADY they are held stable.
- One beat per cycle at full throughput. There are no idle cycles between packets.
- Final handshake at cycle H: `done`=1 at H+1. A new `start` is accepted from H+2.
- `pkts_sent` updates the cycle after the TLAST handshake.

## Configuration
- `LDP_GEN_CHECKSUM_EN` defined: each packet gains a trailing CSUM beat carrying the XOR checksum, and TLAST moves to that beat. Packet length is `beat_len+1`.
- Not defined: no CSUM state and no XOR accumulator; packets are exactly `beat_len` beats.

## Structure
- Shared package `ldp_pkg`:
  - state enum (IDLE, SEND, CSUM, FINISH)
  - `LDP_WORD_W`=32
  - function replicating a 32-bit word to DW.
- One natural sub-module, `ldp_beat_fmt`: registered TDATA/TLAST output stage with hold-on-stall, and the XOR accumulator.

## Test plan
- `packet_count`=2, `packet_beats`=3, TREADY tied 1, checksum off → 6 beats, words 0..5, TLAST on beats 2 and 5. `done` 1 cycle after the 6th beat; `pkts_sent`=2.
- Same stimulus with `LDP_GEN_CHECKSUM_EN` → 8 beats: 0,1,2,CSUM=0^1^2=3,3,4,5,CSUM=3^4^5=2. TLAST only on the CSUM beats.
- `packet_count`=1, `packet_beats`=4, TREADY toggling with 1-in-3 duty → TDATA/TLAST stable throughout every stall; words 0..3 in order.
- `packet_count`=0 → no TVALID; `done` at T+1; `pkts_sent`=0. Also `packet_beats`=0 with count 1 → single 1-beat packet, TLAST=1, word 0.
- `start` re-pulsed mid-burst (count 3, beats 2) → ignored; exactly 6 beats; a single `done` pulse.
- Reset asserted mid-packet (count 4, beats 8, after 5 beats) → TVALID=0, `busy`=0, `pkts_sent`=0 the next cycle. A subsequent start restarts at word 0.
